// File: rtl/clk_mon_pkg.sv
// Shared constants and helpers for the clock activity monitor.
package clk_mon_pkg;

  localparam int NCH_DEF   = 4;
  localparam int CNT_W_DEF = 24;
  localparam int GATE_DEF  = 50_000_000;
  localparam int SYNC_DEF  = 2;
  localparam int BLINK_DEF = 21;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int SEL_W_DEF = sel_width(NCH_DEF);

endpackage

// File: rtl/clk_mon_chan.sv
// One monitored channel: synchroniser, edge detect, window count,
// latched result flags and blink counter.
module clk_mon_chan
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int BLINK_BIT   = BLINK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             term,
  output logic [CNT_W-1:0] latched,
  output logic [CNT_W-1:0] closing,
  output logic             alive,
  output logic             ovf,
  output logic             led
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic                   pulse;
  logic [CNT_W-1:0]       win;
  logic                   win_ovf;
  logic                   at_max;
  logic [BLINK_BIT:0]     blink;

  assign pulse  = sync[SYNC_STAGES-1] & ~sync_q;
  assign at_max = (win == MAX);

  // Window value including this cycle's edge, saturating.
  assign closing = (pulse && !at_max) ? win + CNT_W'(1) : win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      sync_q  <= 1'b0;
      win     <= '0;
      win_ovf <= 1'b0;
      latched <= '0;
      alive   <= 1'b0;
      ovf     <= 1'b0;
      blink   <= '0;
      led     <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig};
      sync_q <= sync[SYNC_STAGES-1];
      blink  <= blink + (BLINK_BIT+1)'(pulse);
      led    <= blink[BLINK_BIT];
      if (term) begin
        win     <= '0;
        win_ovf <= 1'b0;
        latched <= closing;
        ovf     <= win_ovf | (pulse & at_max);
        alive   <= |closing;
      end else if (pulse) begin
        if (at_max)
          win_ovf <= 1'b1;
        else
          win <= closing;
      end
    end
  end

endmodule

// File: rtl/clk_activity_monitor.sv
// Multi-channel edge-rate monitor: gate timer, done pulse and
// registered readout mux over the per-channel units.
module clk_activity_monitor
  import clk_mon_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int GATE_CYCLES = GATE_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int BLINK_BIT   = BLINK_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            sig_in,
  input  logic [sel_width(NCH)-1:0] sel,
  output logic [CNT_W-1:0]          count_out,
  output logic                      done,
  output logic [NCH-1:0]            alive,
  output logic [NCH-1:0]            ovf,
  output logic [NCH-1:0]            led
);

  localparam int SEL_W  = sel_width(NCH);
  localparam int GATE_W = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST =
    GATE_W'(GATE_CYCLES - 1);

  logic              armed;
  logic [GATE_W-1:0] gate;
  logic              term;
  logic [CNT_W-1:0]  lat [NCH];
  logic [CNT_W-1:0]  closing [NCH];
  logic [CNT_W-1:0]  pick;

  assign term = (gate == GATE_LAST);

  // The idle cycle after reset release puts the first done
  // GATE_CYCLES+1 cycles after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
      gate  <= '0;
      done  <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= term;
      if (term)
        gate <= '0;
      else if (armed)
        gate <= gate + GATE_W'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_mon_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .BLINK_BIT   (BLINK_BIT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sig     (sig_in[i]),
      .term    (term),
      .latched (lat[i]),
      .closing (closing[i]),
      .alive   (alive[i]),
      .ovf     (ovf[i]),
      .led     (led[i])
    );
  end

  // Terminal cycle reads the closing value so count_out
  // carries new data the same cycle done rises.
  always_comb begin
    pick = '0;
    for (int i = 0; i < NCH; i++)
      if (SEL_W'(i) == sel)
        pick = term ? closing[i] : lat[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_out <= '0;
    else
      count_out <= pick;
  end

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Bench for clk_activity_monitor: random edges against a
// scheduled-edge window model.
`timescale 1ns/1ps
module tb_clk_activity_monitor;

  localparam int G  = 100;
  localparam int SY = 2;
  localparam int BB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] sig_a = '0;
  logic [1:0] sel_a = '0;
  logic [7:0] cnt_a;
  logic       done_a;
  logic [3:0] alive_a, ovf_a, led_a;

  logic [2:0] sig_b = '0;
  logic [1:0] sel_b = '0;
  logic [3:0] cnt_b;
  logic       done_b;
  logic [2:0] alive_b, ovf_b, led_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_activity_monitor #(
    .NCH(4), .CNT_W(8), .GATE_CYCLES(G),
    .SYNC_STAGES(SY), .BLINK_BIT(BB)
  ) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_a), .sel(sel_a),
    .count_out(cnt_a), .done(done_a), .alive(alive_a),
    .ovf(ovf_a), .led(led_a)
  );

  clk_activity_monitor #(
    .NCH(3), .CNT_W(4), .GATE_CYCLES(G),
    .SYNC_STAGES(SY), .BLINK_BIT(BB)
  ) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .sel(sel_b),
    .count_out(cnt_b), .done(done_b), .alive(alive_b),
    .ovf(ovf_b), .led(led_b)
  );

  // Stimulus generator: 0 low, 1 period 4, 2/4/5 random, 3 manual
  int         mode_a[4] = '{default: 0};
  int         mode_b[3] = '{default: 0};
  logic [3:0] man_a = '0;
  int         ph = 0;

  function automatic logic gen(input int m, input int p,
                               input logic man);
    case (m)
      1: return (p % 4) < 2;
      2: return $urandom_range(0, 3) == 0;
      3: return man;
      4: return $urandom_range(0, 1) == 1;
      5: return $urandom_range(0, 15) == 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    #1;
    ph++;
    for (int i = 0; i < 4; i++)
      sig_a[i] = gen(mode_a[i], ph, man_a[i]);
    for (int i = 0; i < 3; i++)
      sig_b[i] = gen(mode_b[i], ph, 1'b0);
  end

  // Reference model: each sampled rise becomes a count SY edges
  // later; windows close on edges 1+k*G after release.
  int         q[2];
  logic [3:0] prv[2];
  int         pend[2][4][$];
  int         win[2][4];
  int         tot[2][4];
  int         lat[2][4];
  logic [3:0] e_alive[2], e_ovf[2], e_led[2];
  logic       e_done[2];
  int         e_cnt[2];
  int         nch_of[2] = '{4, 3};
  int         max_of[2] = '{255, 15};

  task automatic mstep(input int d, input logic [3:0] s,
                       input int sl);
    if (rst) begin
      q[d] = 0;
      prv[d] = '0;
      e_alive[d] = '0;
      e_ovf[d] = '0;
      e_led[d] = '0;
      e_done[d] = 1'b0;
      e_cnt[d] = 0;
      for (int c = 0; c < 4; c++) begin
        pend[d][c].delete();
        win[d][c] = 0;
        tot[d][c] = 0;
        lat[d][c] = 0;
      end
      return;
    end
    q[d]++;
    e_done[d] = (q[d] > 1) && ((q[d] - 1) % G == 0);
    for (int c = 0; c < nch_of[d]; c++) begin
      if (s[c] && !prv[d][c])
        pend[d][c].push_back(q[d] + SY);
      prv[d][c] = s[c];
      e_led[d][c] = ((tot[d][c] >> BB) & 1) != 0;
      if (pend[d][c].size() > 0 && pend[d][c][0] == q[d]) begin
        void'(pend[d][c].pop_front());
        win[d][c]++;
        tot[d][c]++;
      end
      if (e_done[d]) begin
        lat[d][c] = (win[d][c] > max_of[d]) ? max_of[d] : win[d][c];
        e_ovf[d][c] = win[d][c] > max_of[d];
        e_alive[d][c] = win[d][c] > 0;
        win[d][c] = 0;
      end
    end
    e_cnt[d] = (sl < nch_of[d]) ? lat[d][sl] : 0;
  endtask

  always @(posedge clk) begin
    mstep(0, sig_a, int'(sel_a));
    mstep(1, {1'b0, sig_b}, int'(sel_b));
  end

  task automatic test_reset();
    int n;
    bit seen;
    rst = 1'b1;
    mode_a = '{2, 2, 2, 2};
    mode_b = '{2, 2, 2};
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({done_a, alive_a, ovf_a, led_a, cnt_a,
           done_b, alive_b, ovf_b, led_b, cnt_b} !== '0) begin
        errors++;
        $display("FAIL reset_hold got a=%b%b%b%b/%0d b=%b%b%b%b/%0d want 0",
          done_a, alive_a, ovf_a, led_a, cnt_a,
          done_b, alive_b, ovf_b, led_b, cnt_b);
      end
    end
    mode_a = '{0, 0, 0, 0};
    mode_b = '{0, 0, 0};
    rst = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 3 * G) begin
      @(negedge clk);
      n++;
      if (done_a) begin
        seen = 1;
      end else begin
        checks++;
        if ({alive_a, ovf_a, led_a, cnt_a} !== '0) begin
          errors++;
          $display("FAIL pre_first_done cyc %0d got %b %b %b %0d want 0",
            n, alive_a, ovf_a, led_a, cnt_a);
        end
      end
    end
    checks++;
    if (n !== G + 1) begin
      errors++;
      $display("FAIL first_done_latency got %0d want %0d", n, G + 1);
    end
    checks++;
    if ({done_b, cnt_a, alive_a, ovf_a} !== {1'b1, 8'd0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL first_window got done_b=%b cnt=%0d alive=%b ovf=%b want 1 0 0 0",
        done_b, cnt_a, alive_a, ovf_a);
    end
  endtask

  task automatic test_period();
    int k;
    sel_a = 2'd0;
    mode_a[0] = 1;
    for (int w = 0; w < 2; w++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        checks++;
        if ({done_a, alive_a, ovf_a, led_a, cnt_a} !==
            {e_done[0], e_alive[0], e_ovf[0], e_led[0], 8'(e_cnt[0])}) begin
          errors++;
          $display("FAIL period_model w%0d got %b %b %b %b %0d want %b %b %b %b %0d",
            w, done_a, alive_a, ovf_a, led_a, cnt_a, e_done[0], e_alive[0],
            e_ovf[0], e_led[0], e_cnt[0]);
        end
      end while (!done_a && k < 2 * G);
      checks++;
      if (w == 0 && !(cnt_a >= 24 && cnt_a <= 26 && alive_a == 4'b0001
                      && ovf_a == 4'b0000 && done_a)) begin
        errors++;
        $display("FAIL period_first got done=%b cnt=%0d alive=%b ovf=%b want 1 25+-1 0001 0000",
          done_a, cnt_a, alive_a, ovf_a);
      end
      if (w == 1 && {done_a, cnt_a, alive_a, ovf_a} !==
                    {1'b1, 8'd25, 4'b0001, 4'b0000}) begin
        errors++;
        $display("FAIL period_second got done=%b cnt=%0d alive=%b ovf=%b want 1 25 0001 0000",
          done_a, cnt_a, alive_a, ovf_a);
      end
    end
  endtask

  task automatic test_saturation();
    int k;
    sel_b = 2'd1;
    mode_b[1] = 1;
    for (int w = 0; w < 3; w++) begin
      if (w == 1)
        mode_b[1] = 0;
      k = 0;
      do begin
        @(negedge clk);
        k++;
        checks++;
        if ({done_b, alive_b, ovf_b, led_b, cnt_b} !==
            {e_done[1], e_alive[1][2:0], e_ovf[1][2:0], e_led[1][2:0],
             4'(e_cnt[1])}) begin
          errors++;
          $display("FAIL sat_model w%0d got %b %b %b %b %0d want %b %b %b %b %0d",
            w, done_b, alive_b, ovf_b, led_b, cnt_b, e_done[1],
            e_alive[1][2:0], e_ovf[1][2:0], e_led[1][2:0], e_cnt[1]);
        end
      end while (!done_b && k < 2 * G);
      checks++;
      if (w == 0 && {done_b, cnt_b, alive_b, ovf_b} !==
                    {1'b1, 4'd15, 3'b010, 3'b010}) begin
        errors++;
        $display("FAIL sat_full got done=%b cnt=%0d alive=%b ovf=%b want 1 15 010 010",
          done_b, cnt_b, alive_b, ovf_b);
      end
      if (w == 2 && {done_b, cnt_b, alive_b, ovf_b} !==
                    {1'b1, 4'd0, 3'b000, 3'b000}) begin
        errors++;
        $display("FAIL sat_cleared got done=%b cnt=%0d alive=%b ovf=%b want 1 0 000 000",
          done_b, cnt_b, alive_b, ovf_b);
      end
    end
  endtask

  task automatic test_terminal_edge();
    int k;
    sel_a = 2'd2;
    mode_a = '{1, 2, 3, 0};
    mode_b[0] = 1;
    man_a[2] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (q[0] % G != G - 2 && k < 2 * G);
    // sampled next edge, counted SY edges later on the terminal edge
    man_a[2] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      checks++;
      if ({done_a, alive_a, ovf_a, led_a, cnt_a} !==
          {e_done[0], e_alive[0], e_ovf[0], e_led[0], 8'(e_cnt[0])}) begin
        errors++;
        $display("FAIL term_model got %b %b %b %b %0d want %b %b %b %b %0d",
          done_a, alive_a, ovf_a, led_a, cnt_a, e_done[0], e_alive[0],
          e_ovf[0], e_led[0], e_cnt[0]);
      end
    end while (!done_a && k < 2 * G);
    checks++;
    if ({done_a, cnt_a, alive_a[2]} !== {1'b1, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL term_edge_owned got done=%b cnt=%0d alive2=%b want 1 1 1",
        done_a, cnt_a, alive_a[2]);
    end
    man_a[2] = 1'b0;
  endtask

  task automatic test_sel();
    int kexp[4] = '{25, -1, 1, 0};
    int k;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      @(negedge clk);
      checks++;
      if (cnt_a !== 8'(lat[0][s]) ||
          (kexp[s] >= 0 && cnt_a !== 8'(kexp[s]))) begin
        errors++;
        $display("FAIL sel_step %0d got %0d want %0d", s, cnt_a, lat[0][s]);
      end
    end
    sel_b = 2'd3;
    @(negedge clk);
    checks++;
    if (cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL sel_out_of_range got %0d want 0", cnt_b);
    end
    sel_b = 2'd0;
    @(negedge clk);
    checks++;
    if (cnt_b !== 4'(lat[1][0]) || cnt_b !== 4'd15) begin
      errors++;
      $display("FAIL sel_b0 got %0d want 15", cnt_b);
    end
    sel_a = 2'd2;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_a && k < 2 * G);
    checks++;
    if ({done_a, cnt_a, alive_a[2]} !== {1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL term_next_window got done=%b cnt=%0d alive2=%b want 1 0 0",
        done_a, cnt_a, alive_a[2]);
    end
  endtask

  task automatic test_midreset();
    int n;
    sel_a = 2'd0;
    mode_a = '{1, 2, 0, 4};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q[0] % G != 51 && n < 2 * G);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({done_a, alive_a, ovf_a, led_a, cnt_a,
           done_b, alive_b, ovf_b, led_b, cnt_b} !== '0) begin
        errors++;
        $display("FAIL midreset_clear got a=%b%b%b%b/%0d b=%b%b%b%b/%0d want 0",
          done_a, alive_a, ovf_a, led_a, cnt_a,
          done_b, alive_b, ovf_b, led_b, cnt_b);
      end
    end
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if ({done_a, alive_a, ovf_a, led_a, cnt_a, done_b} !==
          {e_done[0], e_alive[0], e_ovf[0], e_led[0], 8'(e_cnt[0]),
           e_done[1]}) begin
        errors++;
        $display("FAIL midreset_model cyc %0d got %b %b %b %b %0d %b want %b %b %b %b %0d %b",
          n, done_a, alive_a, ovf_a, led_a, cnt_a, done_b, e_done[0],
          e_alive[0], e_ovf[0], e_led[0], e_cnt[0], e_done[1]);
      end
    end while (!done_a && n < 3 * G);
    checks++;
    if (n !== G + 1 || !(cnt_a >= 24 && cnt_a <= 26)) begin
      errors++;
      $display("FAIL midreset_window got lat=%0d cnt=%0d want lat=%0d cnt=25+-1",
        n, cnt_a, G + 1);
    end
  endtask

  task automatic test_random();
    mode_a = '{2, 4, 5, 0};
    mode_b = '{4, 5, 2};
    repeat (3 * G + 5) begin
      @(negedge clk);
      checks++;
      if ({done_a, alive_a, ovf_a, led_a, cnt_a} !==
          {e_done[0], e_alive[0], e_ovf[0], e_led[0], 8'(e_cnt[0])}) begin
        errors++;
        $display("FAIL rand_a got %b %b %b %b %0d want %b %b %b %b %0d",
          done_a, alive_a, ovf_a, led_a, cnt_a, e_done[0], e_alive[0],
          e_ovf[0], e_led[0], e_cnt[0]);
      end
      checks++;
      if ({done_b, alive_b, ovf_b, led_b, cnt_b} !==
          {e_done[1], e_alive[1][2:0], e_ovf[1][2:0], e_led[1][2:0],
           4'(e_cnt[1])}) begin
        errors++;
        $display("FAIL rand_b got %b %b %b %b %0d want %b %b %b %b %0d",
          done_b, alive_b, ovf_b, led_b, cnt_b, e_done[1],
          e_alive[1][2:0], e_ovf[1][2:0], e_led[1][2:0], e_cnt[1]);
      end
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_saturation();
    test_terminal_edge();
    test_sel();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
